// File: rtl/gray_tx.sv
// ============================================================================
//  Module      : gray_tx
//  Description : Gray-code stimulus transmitter for the loopback latency
//                checker. Steps a binary counter at a programmable rate for a
//                programmable burst and drives its registered Gray encoding.
//                Optional macro GRAY_TX_SELFCHECK_EN adds a sticky
//                single-bit-change checker on o_err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gray_tx #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4,
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [DIV_W-1:0] i_div,
    input  logic [LEN_W-1:0] i_len,
    output logic [WIDTH-1:0] o_out,
    output logic             o_step,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_bin;
    logic [DIV_W-1:0]   r_prescale;
    logic [DIV_W-1:0]   r_div_q;
    logic [LEN_W-1:0]   r_sent;
    logic [LEN_W-1:0]   r_len_q;

    logic [WIDTH-1:0]   w_bin_next;
    logic [LEN_W-1:0]   w_sent_next;

    assign w_bin_next  = r_bin + 1'b1;
    assign w_sent_next = r_sent + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_bin      <= '0;
            r_prescale <= '0;
            r_div_q    <= '0;
            r_sent     <= '0;
            r_len_q    <= '0;
            o_out      <= '0;
            o_step     <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_step <= 1'b0;
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        r_div_q    <= i_div;
                        r_len_q    <= i_len;
                        r_prescale <= '0;
                        r_sent     <= '0;
                        r_state    <= S_RUN;
                        o_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Stop wins over a step falling due on the same edge.
                    if (i_stop) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else if (r_prescale == r_div_q) begin
                        r_bin      <= w_bin_next;
                        o_out      <= w_bin_next ^ (w_bin_next >> 1);
                        o_step     <= 1'b1;
                        r_prescale <= '0;
                        r_sent     <= w_sent_next;
                        if ((r_len_q != '0) && (w_sent_next == r_len_q)) begin
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_prescale <= r_prescale + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GRAY_TX_SELFCHECK_EN
    logic [WIDTH-1:0] r_prev_out;
    logic             r_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_out <= '0;
            r_err      <= 1'b0;
        end else if (o_step) begin
            r_prev_out <= o_out;
            if ($countones(o_out ^ r_prev_out) != 1) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_tx.sv
// ============================================================================
//  Module      : tb_gray_tx
//  Description : Directed self-checking bench for gray_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gray_tx;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_start;
    logic       i_stop;
    logic [3:0] i_div;
    logic [7:0] i_len;
    logic [7:0] o_out;
    logic       o_step;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    int n_checks = 0;
    int n_errors = 0;

    gray_tx #(.WIDTH(8), .DIV_W(4), .LEN_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_stop  (i_stop),
        .i_div   (i_div),
        .i_len   (i_len),
        .o_out   (o_out),
        .o_step  (o_step),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"},  {24'h0, o_out}, 32'h00);
        chk({tag, "_step"}, {31'h0, o_step}, 32'h0);
        chk({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, o_done}, 32'h0);
        chk({tag, "_err"},  {31'h0, o_err},  32'h0);
    endtask

    initial begin
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [3];
        logic [7:0] bin_m;
        logic [7:0] gray_m;
        int         steps;

        exp1 = '{8'h01, 8'h03, 8'h02, 8'h06};
        exp2 = '{8'h07, 8'h05, 8'h04};

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_div   = 4'd0;
        i_len   = 8'd0;
        #1;
        chk_all_zero("reset");
        tick();
        tick();
        i_rst_n = 1'b1;

        // 1: div=0, len=4, words on consecutive edges
        i_div = 4'd0; i_len = 8'd4; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("t1_e0_busy", {31'h0, o_busy}, 32'h1);
        chk("t1_e0_out",  {24'h0, o_out},  32'h00);
        chk("t1_e0_step", {31'h0, o_step}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_out",  {24'h0, o_out},  {24'h0, exp1[i]});
            chk("t1_step", {31'h0, o_step}, 32'h1);
            chk("t1_done", {31'h0, o_done}, (i == 3) ? 32'h1 : 32'h0);
            chk("t1_busy", {31'h0, o_busy}, (i == 3) ? 32'h0 : 32'h1);
        end
        tick();
        chk("t1_idle_out",  {24'h0, o_out},  32'h06);
        chk("t1_idle_step", {31'h0, o_step}, 32'h0);
        chk("t1_idle_done", {31'h0, o_done}, 32'h0);
        chk("t1_idle_busy", {31'h0, o_busy}, 32'h0);

        // 2: div=2, len=3, sequence continues from the last value
        i_div = 4'd2; i_len = 8'd3; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        steps = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (o_step) steps++;
            chk("t2_step", {31'h0, o_step}, (c % 3 == 0) ? 32'h1 : 32'h0);
            chk("t2_done", {31'h0, o_done}, (c == 9) ? 32'h1 : 32'h0);
            if (c % 3 == 0)
                chk("t2_out", {24'h0, o_out}, {24'h0, exp2[c/3 - 1]});
        end
        tick();
        chk("t2_nsteps",    steps, 32'd3);
        chk("t2_idle_busy", {31'h0, o_busy}, 32'h0);
        chk("t2_idle_out",  {24'h0, o_out},  32'h04);

        // 3: continuous run across the wrap
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("t3_reset");
        tick();
        i_rst_n = 1'b1;
        i_div = 4'd0; i_len = 8'd0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        bin_m = 8'h00;
        for (int k = 1; k <= 261; k++) begin
            tick();
            bin_m  = bin_m + 8'd1;
            gray_m = bin_m ^ (bin_m >> 1);
            chk("t3_out",  {24'h0, o_out},  {24'h0, gray_m});
            chk("t3_step", {31'h0, o_step}, 32'h1);
            chk("t3_busy", {31'h0, o_busy}, 32'h1);
            if (k == 128) chk("t3_step128", {24'h0, o_out}, 32'hC0);
            if (k == 256) chk("t3_step256", {24'h0, o_out}, 32'h00);
        end
        chk("t3_err", {31'h0, o_err}, 32'h0);

        // 4: stop when a step is due
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("t4_step", {31'h0, o_step}, 32'h0);
        chk("t4_busy", {31'h0, o_busy}, 32'h0);
        chk("t4_done", {31'h0, o_done}, 32'h0);
        chk("t4_out",  {24'h0, o_out},  32'h07);
        tick();
        chk("t4_hold_out",  {24'h0, o_out},  32'h07);
        chk("t4_hold_busy", {31'h0, o_busy}, 32'h0);
        chk("t4_hold_step", {31'h0, o_step}, 32'h0);

        // 5: asynchronous reset mid-burst
        i_div = 4'd1; i_len = 8'd10; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        chk("t5_pre_out",  {24'h0, o_out},  32'h05);
        chk("t5_pre_busy", {31'h0, o_busy}, 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        #1;
        i_rst_n = 1'b1;
        tick();
        chk("t5_idle_busy", {31'h0, o_busy}, 32'h0);
        chk("t5_idle_out",  {24'h0, o_out},  32'h00);
        tick();
        chk("t5_idle2_busy", {31'h0, o_busy}, 32'h0);
        chk("t5_idle2_step", {31'h0, o_step}, 32'h0);

        // 6: start+stop in IDLE, start during RUN
        i_div = 4'd0; i_len = 8'd3; i_start = 1'b1; i_stop = 1'b1;
        tick();
        chk("t6_ss_busy", {31'h0, o_busy}, 32'h0);
        tick();
        chk("t6_ss_busy2", {31'h0, o_busy}, 32'h0);
        chk("t6_ss_step",  {31'h0, o_step}, 32'h0);
        i_stop = 1'b0;
        tick();
        i_start = 1'b0;
        chk("t6_e0_busy", {31'h0, o_busy}, 32'h1);
        tick();
        chk("t6_s1_out", {24'h0, o_out}, 32'h01);
        i_start = 1'b1; i_len = 8'd8;
        tick();
        i_start = 1'b0;
        chk("t6_s2_out",  {24'h0, o_out},  32'h03);
        chk("t6_s2_done", {31'h0, o_done}, 32'h0);
        tick();
        chk("t6_s3_out",  {24'h0, o_out},  32'h02);
        chk("t6_s3_done", {31'h0, o_done}, 32'h1);
        chk("t6_s3_busy", {31'h0, o_busy}, 32'h0);
        tick();
        chk("t6_end_out",  {24'h0, o_out},  32'h02);
        chk("t6_end_step", {31'h0, o_step}, 32'h0);
        chk("t6_end_busy", {31'h0, o_busy}, 32'h0);
        chk("t6_end_err",  {31'h0, o_err},  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
